// File: rtl/vdp_g1_fetch.sv
// Graphics I VRAM fetch sequencer: name/pattern/color DMA reads per tile,
// 8 pixel clocks per tile, 32 tiles per line, with a CPU window in slots 6-7.
module vdp_g1_fetch #(
   parameter int VRAM_SIZE       = 8192,
   parameter int VRAM_ADDR_WIDTH = $clog2(VRAM_SIZE)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       enable,
   input  logic                       line_start,
   input  logic [7:0]                 row,
   input  logic [7:0]                 reg2,
   input  logic [7:0]                 reg3,
   input  logic [7:0]                 reg4,
   output logic [VRAM_ADDR_WIDTH-1:0] dma_addr,
   output logic                       dma_rd_tick,
   input  logic [7:0]                 vram_dout,
   output logic [7:0]                 pat_out,
   output logic [7:0]                 color_out,
   output logic                       tile_valid,
   output logic [4:0]                 tile_col,
   output logic                       cpu_slot,
   output logic                       busy,
   output logic                       line_done
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t                     state_q, state_d;
   logic [2:0]                 slot_q, slot_d;
   logic [4:0]                 tile_q, tile_d;
   logic [7:0]                 row_q, row_d;
   logic                       stop_q, stop_d;   // enable dropped during this tile
   logic [7:0]                 name_byte, pat_hold, pat_q, color_q;
   logic [4:0]                 col_q;
   logic [VRAM_ADDR_WIDTH-1:0] addr_q;
   logic [13:0]                addr14;
   logic                       start_ok, deliver;
   logic                       unused_bits;

   // Upper register bits have no meaning in Graphics I.
   assign unused_bits = ^{reg2[7:4], reg4[7:3], addr14};

   // Sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         slot_q  <= '0;
         tile_q  <= '0;
         row_q   <= '0;
         stop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         tile_q  <= tile_d;
         row_q   <= row_d;
         stop_q  <= stop_d;
      end
   end

   // Next-state, slot decode and strobes
   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      tile_d      = tile_q;
      row_d       = row_q;
      stop_d      = stop_q;
      busy        = (state_q == RUN);
      start_ok    = line_start && enable && (row <= 8'd191);
      dma_rd_tick = 1'b0;
      deliver     = 1'b0;
      line_done   = 1'b0;
      cpu_slot    = 1'b1;
      addr14      = '0;
      // 14-bit TMS9918 addresses; color table base is reg3 * 64.
      case (slot_q)
         3'd0, 3'd1: addr14 = {reg2[3:0], row_q[7:3], tile_q};
         3'd2, 3'd3: addr14 = {reg4[2:0], name_byte, row_q[2:0]};
         default:    addr14 = {reg3, 1'b0, name_byte[7:3]};
      endcase
      if (state_q == RUN) begin
         dma_rd_tick = (slot_q == 3'd0) || (slot_q == 3'd2) || (slot_q == 3'd4);
         cpu_slot    = (slot_q >= 3'd6);
         slot_d      = slot_q + 3'd1;
         if (!enable) stop_d = 1'b1;
         if (start_ok) begin
            // restart: drop the partial tile, begin again at tile 0
            slot_d = '0;
            tile_d = '0;
            row_d  = row;
            stop_d = 1'b0;
         end else begin
            deliver = (slot_q == 3'd5);
            if (slot_q == 3'd7) begin
               tile_d = tile_q + 5'd1;
               if (stop_q || !enable) begin
                  state_d = IDLE;
               end else if (tile_q == 5'd31) begin
                  line_done = 1'b1;
                  state_d   = IDLE;
               end
            end
         end
      end else if (start_ok) begin
         state_d = RUN;
         slot_d  = '0;
         tile_d  = '0;
         row_d   = row;
         stop_d  = 1'b0;
      end
   end

   // Read data capture and delivered-tile hold registers
   always_ff @(posedge clk) begin
      if (reset) begin
         name_byte <= '0;
         pat_hold  <= '0;
         pat_q     <= '0;
         color_q   <= '0;
         col_q     <= '0;
         addr_q    <= '0;
      end else begin
         addr_q <= dma_addr;
         if (busy && slot_q == 3'd1) name_byte <= vram_dout;
         if (busy && slot_q == 3'd3) pat_hold  <= vram_dout;
         if (deliver) begin
            pat_q   <= pat_hold;
            color_q <= vram_dout;
            col_q   <= tile_q;
         end
      end
   end

   // Address is live only on the issue clock and held until the next read.
   assign dma_addr   = dma_rd_tick ? addr14[VRAM_ADDR_WIDTH-1:0] : addr_q;
   // Color byte arrives in slot 5, so the delivered tile bypasses the hold regs.
   assign tile_valid = deliver;
   assign pat_out    = deliver ? pat_hold  : pat_q;
   assign color_out  = deliver ? vram_dout : color_q;
   assign tile_col   = deliver ? tile_q    : col_q;

endmodule

// File: tb/tb_vdp_g1_fetch.sv
module tb_vdp_g1_fetch;
   logic        clk, reset, enable, line_start;
   logic [7:0]  row, reg2, reg3, reg4;
   logic [12:0] dma_addr;
   logic        dma_rd_tick;
   logic [7:0]  vram_dout, pat_out, color_out;
   logic        tile_valid, cpu_slot, busy, line_done;
   logic [4:0]  tile_col;

   vdp_g1_fetch #(.VRAM_SIZE(8192)) dut (
      .clk(clk), .reset(reset), .enable(enable), .line_start(line_start),
      .row(row), .reg2(reg2), .reg3(reg3), .reg4(reg4),
      .dma_addr(dma_addr), .dma_rd_tick(dma_rd_tick), .vram_dout(vram_dout),
      .pat_out(pat_out), .color_out(color_out), .tile_valid(tile_valid),
      .tile_col(tile_col), .cpu_slot(cpu_slot), .busy(busy), .line_done(line_done)
   );

   initial clk = 1'b0;
   always #20 clk = ~clk;

   int checks = 0, errors = 0;
   int cyc = 0;
   int ls_cyc;

   // VRAM behavioural model: data valid the clock after the read strobe
   logic [7:0] mem [0:8191];
   initial vram_dout = 8'h00;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (dma_rd_tick) vram_dout <= mem[dma_addr];
   end

   // Event logs and protocol monitors, sampled mid-cycle
   logic [12:0] rd_q[$];
   int          rd_cyc[$];
   logic [20:0] tv_q[$];
   int          tv_cyc[$];
   int          done_cyc[$];
   int          busy_cnt, viol_ov, viol_cc;
   logic        prev_tick = 1'b0;

   always @(negedge clk) begin
      if (dma_rd_tick) begin rd_q.push_back(dma_addr); rd_cyc.push_back(cyc); end
      if (tile_valid) begin tv_q.push_back({tile_col, pat_out, color_out}); tv_cyc.push_back(cyc); end
      if (line_done) done_cyc.push_back(cyc);
      if (busy) busy_cnt++;
      if (dma_rd_tick && cpu_slot) viol_ov++;
      if (dma_rd_tick && prev_tick) viol_cc++;
      prev_tick = dma_rd_tick;
   end

   task automatic clear_logs();
      rd_q.delete(); rd_cyc.delete(); tv_q.delete(); tv_cyc.delete(); done_cyc.delete();
      busy_cnt = 0; viol_ov = 0; viol_cc = 0;
   endtask

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic fill_mem_random();
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
   endtask

   task automatic start_line(input logic en, input logic [7:0] r, r2, r3, r4);
      @(posedge clk); #1;
      enable = en; row = r; reg2 = r2; reg3 = r3; reg4 = r4;
      line_start = 1'b1; ls_cyc = cyc;
      @(posedge clk); #1;
      line_start = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) begin @(posedge clk); #1; end
   endtask

   // Reference: TMS9918 Graphics I address arithmetic and slot timing
   task automatic check_line(input logic [7:0] r, r2, r3, r4,
                             input int rd_off, tv_off, ntiles, ls);
      int na, pa, ca;
      logic [7:0] nb;
      if (rd_q.size() < rd_off + 3*ntiles || tv_q.size() < tv_off + ntiles) begin
         chk("model_len", rd_q.size() * 1000 + tv_q.size(), (rd_off + 3*ntiles) * 1000 + tv_off + ntiles);
         return;
      end
      for (int t = 0; t < ntiles; t++) begin
         na = ((r2 & 15) * 1024 + (r / 8) * 32 + t) % 8192;
         nb = mem[na];
         pa = ((r4 & 7) * 2048 + nb * 8 + r % 8) % 8192;
         ca = (r3 * 64 + nb / 8) % 8192;
         chk("rd_name_addr", rd_q[rd_off + 3*t],     na);
         chk("rd_pat_addr",  rd_q[rd_off + 3*t + 1], pa);
         chk("rd_col_addr",  rd_q[rd_off + 3*t + 2], ca);
         chk("rd_name_cyc",  rd_cyc[rd_off + 3*t],   ls + 1 + 8*t);
         chk("rd_col_cyc",   rd_cyc[rd_off + 3*t + 2], ls + 5 + 8*t);
         chk("tile_data",    tv_q[tv_off + t], {5'(t), mem[pa], mem[ca]});
         chk("tile_cyc",     tv_cyc[tv_off + t], ls + 6 + 8*t);
      end
   endtask

   task automatic run_and_check(input logic en, input logic [7:0] r, r2, r3, r4,
                                input int exp_ticks, exp_busy, exp_done);
      clear_logs();
      start_line(en, r, r2, r3, r4);
      repeat (270) @(negedge clk);
      chk("rd_count",   rd_q.size(),     exp_ticks);
      chk("tile_count", tv_q.size(),     exp_ticks / 3);
      chk("done_count", done_cyc.size(), exp_done);
      chk("busy_cycles", busy_cnt,       exp_busy);
      chk("cpu_vs_dma", viol_ov, 0);
      chk("dma_b2b",    viol_cc, 0);
      if (exp_done != 0) begin
         check_line(r, r2, r3, r4, 0, 0, 32, ls_cyc);
         if (done_cyc.size() > 0) chk("done_latency", done_cyc[0] - ls_cyc, 256);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_tick"},  dma_rd_tick, 0);
      chk({tag, "_addr"},  dma_addr, 0);
      chk({tag, "_pat"},   pat_out, 0);
      chk({tag, "_color"}, color_out, 0);
      chk({tag, "_tv"},    tile_valid, 0);
      chk({tag, "_col"},   tile_col, 0);
      chk({tag, "_busy"},  busy, 0);
      chk({tag, "_done"},  line_done, 0);
      chk({tag, "_cpu"},   cpu_slot, 1);
   endtask

   typedef struct {
      logic en; logic [7:0] row, r2, r3, r4;
      int exp_ticks, exp_busy, exp_done;
   } vec_t;
   vec_t vecs[6];

   initial begin
      vecs[0] = '{1'b1, 8'd191, 8'h0F, 8'hFF, 8'h07, 96, 256, 1};
      vecs[1] = '{1'b1, 8'd192, 8'h06, 8'h80, 8'h00,  0,   0, 0};
      vecs[2] = '{1'b0, 8'd40,  8'h06, 8'h80, 8'h00,  0,   0, 0};
      vecs[3] = '{1'b1, 8'd200, 8'h06, 8'h80, 8'h00,  0,   0, 0};
      vecs[4] = '{1'b1, 8'd8,   8'h02, 8'h2C, 8'h03, 96, 256, 1};
      vecs[5] = '{1'b1, 8'd255, 8'h01, 8'h00, 8'h00,  0,   0, 0};

      reset = 1'b1; enable = 1'b0; line_start = 1'b0;
      row = 0; reg2 = 0; reg3 = 0; reg4 = 0;
      fill_mem_random();
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_vals("reset");
      @(posedge clk); #1;
      reset = 1'b0;

      // Directed line: row 0 with known tile-0 bytes
      mem[13'h1800] = 8'h41; mem[13'h0208] = 8'h3C; mem[13'h0008] = 8'hF1;
      run_and_check(1'b1, 8'd0, 8'h06, 8'h80, 8'h00, 96, 256, 1);
      if (rd_q.size() > 0) chk("first_addr", rd_q[0], 13'h1800);
      if (tv_q.size() > 0) begin
         chk("first_pat",   tv_q[0][15:8], 8'h3C);
         chk("first_color", tv_q[0][7:0],  8'hF1);
         chk("first_col",   tv_q[0][20:16], 0);
         chk("first_tv_lat", tv_cyc[0] - ls_cyc, 6);
      end

      // Directed line: row 13, every name byte 0xFF
      for (int t = 0; t < 32; t++) mem[13'h0420 + t] = 8'hFF;
      run_and_check(1'b1, 8'd13, 8'h01, 8'h80, 8'h00, 96, 256, 1);
      if (rd_q.size() == 96) begin
         chk("r13_name0", rd_q[0],  13'h0420);
         chk("r13_pat",   rd_q[1],  13'h07FD);
         chk("r13_color", rd_q[2],  13'h001F);
         chk("r13_name31", rd_q[93], 13'h043F);
      end

      // Table vectors: boundary rows, disabled display, register extremes
      for (int i = 0; i < 6; i++)
         run_and_check(vecs[i].en, vecs[i].row, vecs[i].r2, vecs[i].r3, vecs[i].r4,
                       vecs[i].exp_ticks, vecs[i].exp_busy, vecs[i].exp_done);

      // Randomized lines against the reference
      for (int i = 0; i < 6; i++) begin
         fill_mem_random();
         run_and_check(1'b1, 8'($urandom_range(191, 0)), 8'($urandom), 8'($urandom),
                       8'($urandom), 96, 256, 1);
      end

      // Restart at tile 10 slot 3 with row 20
      begin
         int ls1, ls2;
         fill_mem_random();
         clear_logs();
         start_line(1'b1, 8'd0, 8'h06, 8'h80, 8'h00);
         ls1 = ls_cyc;
         wait_until(ls1 + 83);
         start_line(1'b1, 8'd20, 8'h06, 8'h80, 8'h00);
         ls2 = ls_cyc;
         chk("restart_slot_pos", ls2 - ls1, 84);
         repeat (270) @(negedge clk);
         chk("rs_rd_count", rd_q.size(), 128);
         chk("rs_tv_count", tv_q.size(), 42);
         chk("rs_done_count", done_cyc.size(), 1);
         if (done_cyc.size() > 0) chk("rs_done_lat", done_cyc[0] - ls2, 256);
         check_line(8'd0,  8'h06, 8'h80, 8'h00, 0, 0, 10, ls1);
         check_line(8'd20, 8'h06, 8'h80, 8'h00, 32, 10, 32, ls2);
         chk("rs_cpu_vs_dma", viol_ov, 0);
         chk("rs_dma_b2b", viol_cc, 0);
      end

      // Reset during slot 2 of tile 5
      clear_logs();
      start_line(1'b1, 8'd0, 8'h06, 8'h80, 8'h00);
      wait_until(ls_cyc + 43);
      chk("pre_reset_tick", dma_rd_tick, 1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_vals("midreset");
      @(posedge clk); #1;
      reset = 1'b0;
      clear_logs();
      repeat (100) @(negedge clk);
      chk("post_reset_ticks", rd_q.size(), 0);
      chk("post_reset_busy", busy_cnt, 0);

      // Enable drops during tile 3: finish tile, no line_done
      fill_mem_random();
      clear_logs();
      start_line(1'b1, 8'd16, 8'h03, 8'h11, 8'h05);
      wait_until(ls_cyc + 27);
      enable = 1'b0;
      repeat (270) @(negedge clk);
      chk("en_rd_count", rd_q.size(), 12);
      chk("en_tv_count", tv_q.size(), 4);
      chk("en_done_count", done_cyc.size(), 0);
      chk("en_busy_cycles", busy_cnt, 32);
      check_line(8'd16, 8'h03, 8'h11, 8'h05, 0, 0, 4, ls_cyc);
      enable = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
